// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared encodings for the multicycle ARM controller.
// FSM state codes, ALU operation codes, instruction field constants and
// datapath mux encodings, plus small helpers that decode the DP command.
// Optional feature macro used by the controller: MC_MEM_TIMEOUT_EN.
package mc_ctrl_pkg;

    // FSM state encoding (4-bit, legacy-compatible localparam style)
    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXECR  = 4'd6;
    localparam logic [3:0] S_EXECI  = 4'd7;
    localparam logic [3:0] S_ALUWB  = 4'd8;
    localparam logic [3:0] S_BRANCH = 4'd9;
    localparam logic [3:0] S_FAULT  = 4'd10;

    // ALU operation codes; zero-extended to the alu_control width
    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_AND = 2'd2;
    localparam logic [1:0] ALU_ORR = 2'd3;

    // instr[27:26] opcode classes
    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    // instr[24:21] data-processing commands
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    // result_src encodings
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    // alu_src_b encodings
    localparam logic [1:0] SRCB_RM   = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // Map a DP command onto an ALU operation; unknown commands act as ADD.
    function automatic logic [1:0] dp_alu_code(input logic [3:0] cmd);
        logic [1:0] code;
        case (cmd)
            CMD_SUB, CMD_CMP: code = ALU_SUB;
            CMD_AND:          code = ALU_AND;
            CMD_ORR:          code = ALU_ORR;
            default:          code = ALU_ADD;
        endcase
        return code;
    endfunction

    // Logical commands only touch N and Z; arithmetic ones write all of NZCV.
    function automatic logic dp_is_logical(input logic [3:0] cmd);
        return (cmd == CMD_AND) || (cmd == CMD_ORR);
    endfunction

endpackage

// File: rtl/mc_condcheck.sv
// mc_condcheck: ARM condition-field evaluation against NZCV.
// Purely combinational. Flag order is {N, Z, C, V}. Code 1111 is treated
// as "never" so such instructions are skipped like a failed condition.
module mc_condcheck (
    input  logic [3:0] cond_i,
    input  logic [3:0] flags_i,
    output logic       cond_ok_o
);

    logic n_f, z_f, c_f, v_f;

    assign n_f = flags_i[3];
    assign z_f = flags_i[2];
    assign c_f = flags_i[1];
    assign v_f = flags_i[0];

    // Standard ARM condition table
    always_comb begin
        cond_ok_o = 1'b0;
        case (cond_i)
            4'b0000: cond_ok_o = z_f;                       // EQ
            4'b0001: cond_ok_o = ~z_f;                      // NE
            4'b0010: cond_ok_o = c_f;                       // CS
            4'b0011: cond_ok_o = ~c_f;                      // CC
            4'b0100: cond_ok_o = n_f;                       // MI
            4'b0101: cond_ok_o = ~n_f;                      // PL
            4'b0110: cond_ok_o = v_f;                       // VS
            4'b0111: cond_ok_o = ~v_f;                      // VC
            4'b1000: cond_ok_o = c_f & ~z_f;                // HI
            4'b1001: cond_ok_o = ~c_f | z_f;                // LS
            4'b1010: cond_ok_o = (n_f == v_f);              // GE
            4'b1011: cond_ok_o = (n_f != v_f);              // LT
            4'b1100: cond_ok_o = ~z_f & (n_f == v_f);       // GT
            4'b1101: cond_ok_o = z_f | (n_f != v_f);        // LE
            4'b1110: cond_ok_o = 1'b1;                      // AL
            default: cond_ok_o = 1'b0;                      // 1111: never
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// mc_controller: FSM-sequenced control for a shared-memory multicycle ARM
// datapath. Holds the FSM, the architectural NZCV register and (optionally)
// the memory wait counter.
// Memory handshake: mem_req is held high with constant address/strobes until
// the cycle in which mem_ready is sampled high; that cycle completes the
// access and the FSM advances on the following edge.
// Optional feature macro: MC_MEM_TIMEOUT_EN -- when defined, a saturating
// wait counter sends the FSM to FAULT after 2^TIMEOUT_W-1 consecutive wait
// cycles; when undefined the controller waits indefinitely and fault is 0.
// All outputs are forced to 0 combinationally while reset is high, so an
// in-flight write strobe drops in the same cycle reset is asserted.
module mc_controller
    import mc_ctrl_pkg::*;
#(
    parameter int ALU_CTRL_W = 4,
    parameter int BE_W       = 4,
    parameter int TIMEOUT_W  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [31:0]              instr,
    input  logic [3:0]               alu_flags,
    input  logic [$clog2(BE_W)-1:0]  byte_off,
    input  logic                     mem_ready,
    output logic                     mem_req,
    output logic                     mem_write,
    output logic [BE_W-1:0]          be,
    output logic                     ir_write,
    output logic                     pc_write,
    output logic                     adr_src,
    output logic                     reg_write,
    output logic [1:0]               result_src,
    output logic                     alu_src_a,
    output logic [1:0]               alu_src_b,
    output logic [ALU_CTRL_W-1:0]    alu_control,
    output logic [1:0]               imm_src,
    output logic [1:0]               reg_src,
    output logic [3:0]               flags,
    output logic                     fault,
    output logic [3:0]               dbg_state
);

    logic [3:0] state_q, state_d;
    logic [3:0] flags_q, flags_d;
    logic [1:0] alu_code;
    logic       cond_ok;
    logic       timeout_hit;

    // Instruction fields
    logic [3:0] cond_f;
    logic [1:0] op_f;
    logic       imm_f;
    logic [3:0] cmd_f;
    logic       up_f;
    logic       byte_f;
    logic       sl_f;      // S bit for DP, L bit for memory

    assign cond_f = instr[31:28];
    assign op_f   = instr[27:26];
    assign imm_f  = instr[25];
    assign cmd_f  = instr[24:21];
    assign up_f   = instr[23];
    assign byte_f = instr[22];
    assign sl_f   = instr[20];

    // Operand/offset bits are consumed by the datapath, not the controller.
    logic unused_instr_bits;
    assign unused_instr_bits = ^instr[19:0];

    mc_condcheck u_condcheck (
        .cond_i    (cond_f),
        .flags_i   (flags_q),
        .cond_ok_o (cond_ok)
    );

`ifdef MC_MEM_TIMEOUT_EN
    localparam logic [TIMEOUT_W-1:0] WAIT_MAX = '1;

    logic [TIMEOUT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic                 mem_access;
    logic                 mem_waiting;
    logic                 fault_q;

    // States that hold mem_req high; matches the FSM output decode below.
    assign mem_access  = (state_q == S_FETCH) || (state_q == S_MEMRD) ||
                         (state_q == S_MEMWR);
    assign mem_waiting = mem_access && !mem_ready;

    // Next wait count: saturating increment while stalled, clear otherwise
    always_comb begin
        wait_cnt_d = '0;
        if (mem_waiting) begin
            wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q
                                                  : wait_cnt_q + TIMEOUT_W'(1);
        end
    end

    // mem_ready has priority: a completing access never counts as a timeout.
    assign timeout_hit = mem_waiting && (wait_cnt_d == WAIT_MAX);

    // Wait counter and sticky fault register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt_q <= '0;
            fault_q    <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            if (timeout_hit) begin
                fault_q <= 1'b1;
            end
        end
    end

    assign fault = fault_q;
`else
    logic [TIMEOUT_W-1:0] unused_timeout_w;
    assign unused_timeout_w = '0;
    assign timeout_hit      = 1'b0;
    assign fault            = 1'b0;
`endif

    // Next state, flag update and Moore/Mealy control outputs
    always_comb begin
        state_d    = state_q;
        flags_d    = flags_q;
        alu_code   = ALU_ADD;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        be         = '0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        adr_src    = 1'b0;
        reg_write  = 1'b0;
        result_src = RES_ALUOUT;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_RM;
        imm_src    = 2'b00;
        reg_src    = 2'b00;

        if (!reset) begin
            imm_src = op_f;
            case (state_q)
                S_FETCH: begin
                    mem_req   = 1'b1;
                    adr_src   = 1'b0;
                    be        = '1;
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_FOUR;
                    alu_code  = ALU_ADD;
                    if (mem_ready) begin
                        ir_write   = 1'b1;
                        pc_write   = 1'b1;
                        result_src = RES_ALU;
                        state_d    = S_DECODE;
                    end
                end
                S_DECODE: begin
                    // PC+8 is formed here for use as R15 by the next state.
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_FOUR;
                    alu_code  = ALU_ADD;
                    if (!cond_ok) begin
                        state_d = S_FETCH;
                    end else begin
                        case (op_f)
                            OP_DP:   state_d = imm_f ? S_EXECI : S_EXECR;
                            OP_MEM:  state_d = S_MEMADR;
                            OP_BR:   state_d = S_BRANCH;
                            default: state_d = S_FETCH;
                        endcase
                    end
                end
                S_MEMADR: begin
                    alu_src_b = SRCB_IMM;
                    alu_code  = up_f ? ALU_ADD : ALU_SUB;
                    state_d   = sl_f ? S_MEMRD : S_MEMWR;
                end
                S_MEMRD, S_MEMWR: begin
                    mem_req = 1'b1;
                    adr_src = 1'b1;
                    be      = byte_f ? (BE_W'(1) << byte_off) : '1;
                    if (state_q == S_MEMWR) begin
                        mem_write  = 1'b1;
                        reg_src[1] = 1'b1;
                    end
                    if (mem_ready) begin
                        state_d = (state_q == S_MEMRD) ? S_MEMWB : S_FETCH;
                    end
                end
                S_MEMWB: begin
                    reg_write  = 1'b1;
                    result_src = RES_DATA;
                    state_d    = S_FETCH;
                end
                S_EXECR, S_EXECI: begin
                    alu_src_b = (state_q == S_EXECI) ? SRCB_IMM : SRCB_RM;
                    alu_code  = dp_alu_code(cmd_f);
                    if (sl_f) begin
                        if (dp_is_logical(cmd_f)) begin
                            flags_d[3:2] = alu_flags[3:2];
                        end else begin
                            flags_d = alu_flags;
                        end
                    end
                    state_d = (cmd_f == CMD_CMP) ? S_FETCH : S_ALUWB;
                end
                S_ALUWB: begin
                    reg_write  = 1'b1;
                    result_src = RES_ALUOUT;
                    state_d    = S_FETCH;
                end
                S_BRANCH: begin
                    reg_src[0] = 1'b1;
                    alu_src_b  = SRCB_IMM;
                    alu_code   = ALU_ADD;
                    result_src = RES_ALU;
                    pc_write   = 1'b1;
                    state_d    = S_FETCH;
                end
                S_FAULT: begin
                    state_d = S_FAULT;
                end
                default: begin
                    state_d = S_FETCH;
                end
            endcase

            if (timeout_hit) begin
                state_d = S_FAULT;
            end
        end
    end

    assign alu_control = reset ? '0 : ALU_CTRL_W'(alu_code);

    // FSM state and architectural flag register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            flags_q <= 4'b0000;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
        end
    end

    assign flags     = flags_q;
    assign dbg_state = state_q;

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Multicycle successor to the single-cycle ARM controller.
- FSM-sequenced control for a shared-memory datapath with a memory ready/wait handshake, an architectural NZCV flag register, and ARM condition evaluation.
- Sits between instruction register/ALU flags and the multicycle datapath; one instruction takes 3–5 states plus memory wait cycles.

Parameters:
- ALU_CTRL_W, 4, width of alu_control; must be ≥2; codes zero-extended.
- BE_W, 4, byte-enable width; a word is BE_W bytes.
- TIMEOUT_W, 8, width of the memory-wait counter; fault after 2^TIMEOUT_W−1 consecutive wait cycles.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- instr  in  32  current IR contents.
- alu_flags  in  4  NZCV from ALU, current cycle.
- byte_off  in  $clog2(BE_W)  low address bits for byte access.
- mem_ready  in  1  memory completes access this cycle.
- mem_req  out  1  memory access request.
- mem_write  out  1  write strobe, qualifies mem_req.
- be  out  BE_W  byte enables.
- ir_write  out  1  load IR.
- pc_write  out  1  load PC.
- adr_src  out  1  0=PC, 1=ALU result.
- reg_write  out  1  register-file write.
- result_src  out  2  00=ALUOut, 01=data, 10=ALU result.
- alu_src_a  out  1  0=Rn, 1=PC.
- alu_src_b  out  2  00=Rm, 01=ext imm, 10=constant 4.
- alu_control  out  ALU_CTRL_W  ALU operation.
- imm_src  out  2  instr[27:26].
- reg_src  out  2  [0]=branch (PC as Rn), [1]=store (Rd as Rm).
- flags  out  4  architectural NZCV.
- fault  out  1  sticky memory-timeout fault.

Behaviour:
- Async reset:
  - state=FETCH, flags=0, counter=0, fault=0.
  - All strobes 0 (mem_req, mem_write, ir_write, pc_write, reg_write); all other outputs 0.
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH, FAULT.
- FETCH:
  - mem_req=1, adr_src=0, alu_src_a=1, alu_src_b=10, alu_control=ADD.
  - Holds while mem_ready=0.
  - In the mem_ready=1 cycle: ir_write=1, pc_write=1, result_src=10, next=DECODE.
- DECODE:
  - Computes PC+8, no strobes.
  - Evaluates cond=instr[31:28] against flags using the standard ARM table; 1111 counts as failed.
  - Failed → FETCH.
  - Otherwise dispatch on op=instr[27:26]:
    - 00 → EXECI if instr[25] else EXECR.
    - 01 → MEMADR.
    - 10 → BRANCH.
    - 11 → FETCH (undefined, treated as NOP).
- MEMADR:
  - alu_src_b=01; alu_control=ADD if instr[23] else SUB.
  - instr[20] → MEMRD, else MEMWR.
- MEMRD/MEMWR:
  - mem_req=1, adr_src=1; MEMWR also drives mem_write=1 and reg_src[1]=1.
  - be = all ones if instr[22]=0, else one-hot at byte_off.
  - Outputs held until the mem_ready=1 cycle; then MEMRD→MEMWB, MEMWR→FETCH.
- MEMWB: reg_write=1, result_src=01 → FETCH.
- EXECR/EXECI:
  - alu_src_b=00 / 01.
  - cmd=instr[24:21]: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 1010 CMP (SUB, no write); other cmd values → ADD.
  - If instr[20]: flags ← alu_flags at the end of this cycle. Logical ops update NZ only; arithmetic ops update NZCV.
  - Next state: ALUWB, or FETCH for CMP.
- ALUWB: reg_write=1, result_src=00 → FETCH.
- BRANCH: reg_src[0]=1, alu_src_b=01, ADD, result_src=10, pc_write=1 → FETCH.
- Wait counter:
  - Increments each cycle mem_req=1 && mem_ready=0; clears on mem_ready or when mem_req=0.
  - Saturating; never wraps.
- Simultaneous mem_ready and counter reaching max: mem_ready wins (access completes).
- FAULT: all strobes 0, fault=1, exits only on reset.
- Reset mid-MEMWR: mem_write drops asynchronously; no further strobes issued.

Optional Feature:
- Macro: MC_MEM_TIMEOUT_EN.
- Defined: wait counter present; on reaching 2^TIMEOUT_W−1 with mem_ready=0, next state is FAULT.
- Undefined: no counter; waits indefinitely; fault tied to 0; FAULT state unreachable.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state enum.
  - ALU codes ALU_ADD=0, ALU_SUB=1, ALU_AND=2, ALU_ORR=3.
  - op constants OP_DP/OP_MEM/OP_BR.
  - DP cmd constants.
  - result_src and alu_src_b encodings.
- Sub-module mc_condcheck: combinational cond(4)+flags(4) → cond_ok.
- FSM, flag register and wait counter stay in mc_controller.

Test Plan:
- ADD r1,r2,r3 (0xE0821003), mem_ready always 1 → state path FETCH, DECODE, EXECR, ALUWB, FETCH; reg_write=1 only in cycle 4; flags unchanged.
- LDR r0,[r1,#4] (0xE5910004), mem_ready low 2 cycles in MEMRD → MEMRD lasts 3 cycles with mem_req=1, adr_src=1, be=1111; MEMWB reg_write=1, result_src=01.
- SUBS r0,r0,r0 (0xE0500000) with alu_flags=0100 in EXECR, then BEQ (0x0A000002) → flags=0100; BRANCH entered with pc_write=1.
- BNE (0x1A000002) with Z=1 → DECODE→FETCH; pc_write only in the FETCH ready cycle.
- STRB (0xE5C10000), byte_off=2, mem_ready never asserted, TIMEOUT_W=4, macro defined → FAULT after 15 wait cycles, fault=1, mem_write=0; stays until reset.
- Reset asserted during MEMWR wait → same cycle: mem_write=0, mem_req=0; after release, state=FETCH and flags=0.
